// File: rtl/aes_result_collector.sv
// Reassembles the AES core's 32-bit result stream into 128-bit blocks (MSB word first),
// queues them in a fall-through FIFO and reports completion/errors. Option: AES_COLLECT_BYTESWAP_EN.
module aes_result_collector #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 9
) (
  input  logic             clkIn,
  input  logic             resetIn,
  input  logic [1:0]       startIn,
  input  logic [LEN_W-1:0] lengthIn,
  input  logic [31:0]      data32In,
  input  logic [3:0]       weIn,
  input  logic [2:0]       doneIn,
  output logic [127:0]     blkOut,
  output logic             blkValidOut,
  input  logic             blkReadyIn,
  output logic             blkDecOut,
  output logic [LEN_W-1:0] countOut,
  output logic             doneOut,
  output logic [1:0]       errOut
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FIFO_FULL = DEPTH[PTR_W:0];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             dec_q, dec_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic [127:0]     pack_q, pack_d;
  logic [1:0]       err_q, err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic [127:0]     fifo_mem_q [DEPTH];

  logic [31:0]  word_in;
  logic         start_ok;
  logic         in_run;
  logic         word_we;
  logic         accept;
  logic         core_done;
  logic         exit_run;
  logic [127:0] pack_next;
  logic [127:0] blk_pack;
  logic [1:0]   idx_next;
  logic         push;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;
  logic         push_ok;
  logic         overflow;
  logic         proto_err;

`ifdef AES_COLLECT_BYTESWAP_EN
  assign word_in = {data32In[7:0], data32In[15:8], data32In[23:16], data32In[31:24]};
`else
  assign word_in = data32In;
`endif

  // Word acceptance, block completion and run termination
  always_comb begin
    start_ok  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                ((startIn == 2'd1) || (startIn == 2'd2));
    in_run    = (state_q == ST_RUN);
    word_we   = (weIn == 4'hF);
    accept    = in_run && word_we && (count_q < len_q);
    core_done = (doneIn == 3'b111);
    exit_run  = in_run && ((count_q == len_q) || core_done);

    pack_next = '0;
    case (idx_q)
      2'd0:    pack_next = {word_in, 96'h0};
      2'd1:    pack_next = {pack_q[127:96], word_in, 64'h0};
      2'd2:    pack_next = {pack_q[127:64], word_in, 32'h0};
      default: pack_next = {pack_q[127:32], word_in};
    endcase

    blk_pack = accept ? pack_next : pack_q;
    idx_next = accept ? (idx_q + 2'd1) : idx_q;
    // The low words are already zero when a partial block is flushed on exit
    push     = (accept && (idx_q == 2'd3)) || (exit_run && (idx_next != 2'd0));

    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FIFO_FULL);
    pop        = !fifo_empty && blkReadyIn;
    push_ok    = push && (!fifo_full || pop);
    overflow   = push && fifo_full && !pop;

    proto_err = ((weIn != 4'h0) && !word_we) ||
                (word_we && !accept) ||
                (in_run && core_done && (count_q < len_q));
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dec_d   = dec_q;
    count_d = count_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    err_d   = err_q | {overflow, proto_err};

    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN:   if (exit_run) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      default:  if (start_ok) state_d = ST_RUN;
    endcase

    if (start_ok) begin
      len_d   = lengthIn;
      dec_d   = (startIn == 2'd2);
      count_d = '0;
      idx_d   = 2'd0;
      pack_d  = '0;
      err_d   = 2'b00;
    end else begin
      if (accept) begin
        count_d = count_q + 1'b1;
        idx_d   = idx_next;
        pack_d  = pack_next;
      end
      if (exit_run) begin
        idx_d  = 2'd0;
        pack_d = '0;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      dec_q    <= 1'b0;
      count_q  <= '0;
      idx_q    <= 2'd0;
      pack_q   <= '0;
      err_q    <= 2'b00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      dec_q    <= dec_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clkIn) begin
    if (!resetIn && push_ok) fifo_mem_q[wr_ptr_q] <= blk_pack;
  end

  assign blkOut      = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign blkValidOut = !fifo_empty;
  assign blkDecOut   = dec_q;
  assign countOut    = count_q;
  assign doneOut     = (state_q == ST_DONE);
  assign errOut      = err_q;

endmodule
